// File: rtl/cpu_clock_controller_pkg.sv
// rtl/cpu_clock_controller_pkg.sv - shared state encoding and default widths for the CPU tick generator
package cpu_clock_controller_pkg;

  localparam int DEF_DIV_WIDTH = 8;
  localparam int DEF_CNT_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP_WAIT = 3'd2,
    ST_STEP_HI   = 3'd3,
    ST_STEP_LO   = 3'd4,
    ST_DONE      = 3'd5
  } cpu_clk_state_t;

endpackage

// File: rtl/cpu_clock_phase_timer.sv
// rtl/cpu_clock_phase_timer.sv - counts one TICK phase of latched DIVIDE+1 cycles
module cpu_clock_phase_timer
  import cpu_clock_controller_pkg::*;
#(
  parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
  input  logic                 MAIN_CLOCK,
  input  logic                 RESET_N,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] divide,
  output logic                 phase_done
);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] div_lat;

  assign phase_done = (cnt == div_lat);

  // The counter parks on the latched ratio so it can never run past it
  always_ff @(posedge MAIN_CLOCK) begin
    if (!RESET_N) begin
      cnt     <= '0;
      div_lat <= '0;
    end else if (load) begin
      cnt     <= '0;
      div_lat <= divide;
    end else if (!phase_done) begin
      cnt <= cnt + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/cpu_clock_controller.sv
// rtl/cpu_clock_controller.sv - programmable CPU TICK generator; CYCLE_COUNT built only with CPU_CLK_CYCLE_COUNT_EN
module cpu_clock_controller
  import cpu_clock_controller_pkg::*;
#(
  parameter int DIV_WIDTH = DEF_DIV_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 MAIN_CLOCK,
  input  logic                 RESET_N,
  input  logic                 START,
  input  logic                 STEP_MODE,
  input  logic                 STEP_REQ,
  input  logic                 PROCESS_FINISHED,
  input  logic [DIV_WIDTH-1:0] DIVIDE,
  output logic                 TICK,
  output logic                 TICK_RISE,
  output logic                 TICK_FALL,
  output logic                 HALTED,
  output logic [CNT_WIDTH-1:0] CYCLE_COUNT
);

  cpu_clk_state_t state, state_n;
  logic tick, tick_n;
  logic stop_pend, stop_n;
  logic load, phase_done, stop_req;

  cpu_clock_phase_timer #(.DIV_WIDTH(DIV_WIDTH)) u_phase_timer (
    .MAIN_CLOCK (MAIN_CLOCK),
    .RESET_N    (RESET_N),
    .load       (load),
    .divide     (DIVIDE),
    .phase_done (phase_done)
  );

  assign stop_req = stop_pend | PROCESS_FINISHED;

  always_comb begin
    state_n = state;
    tick_n  = tick;
    stop_n  = stop_pend;
    load    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        tick_n = 1'b0;
        stop_n = 1'b0;
        if (START && !PROCESS_FINISHED) begin
          load = 1'b1;
          if (STEP_MODE) begin
            state_n = ST_STEP_WAIT;
          end else begin
            state_n = ST_RUN;
            tick_n  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (tick) begin
          // A stop seen during the high phase is held until that phase ends
          stop_n = stop_req;
          if (phase_done) begin
            tick_n = 1'b0;
            load   = 1'b1;
            if (stop_req) begin
              state_n = ST_DONE;
              stop_n  = 1'b0;
            end
          end
        end else if (PROCESS_FINISHED) begin
          state_n = ST_DONE;
        end else if (phase_done) begin
          if (STEP_MODE) begin
            state_n = ST_STEP_WAIT;
          end else begin
            tick_n = 1'b1;
            load   = 1'b1;
          end
        end
      end
      ST_STEP_WAIT: begin
        if (PROCESS_FINISHED) begin
          state_n = ST_DONE;
        end else if (!STEP_MODE) begin
          state_n = ST_RUN;
          tick_n  = 1'b1;
          load    = 1'b1;
        end else if (STEP_REQ) begin
          state_n = ST_STEP_HI;
          tick_n  = 1'b1;
          load    = 1'b1;
        end
      end
      ST_STEP_HI: begin
        stop_n = stop_req;
        if (phase_done) begin
          tick_n = 1'b0;
          if (stop_req) begin
            state_n = ST_DONE;
            stop_n  = 1'b0;
          end else begin
            state_n = ST_STEP_LO;
            load    = 1'b1;
          end
        end
      end
      ST_STEP_LO: begin
        if (PROCESS_FINISHED) begin
          state_n = ST_DONE;
        end else if (phase_done) begin
          state_n = ST_STEP_WAIT;
        end
      end
      default: begin
        state_n = ST_IDLE;
        tick_n  = 1'b0;
        stop_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge MAIN_CLOCK) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      tick      <= 1'b0;
      stop_pend <= 1'b0;
      TICK_RISE <= 1'b0;
      TICK_FALL <= 1'b0;
      HALTED    <= 1'b0;
    end else begin
      state     <= state_n;
      tick      <= tick_n;
      stop_pend <= stop_n;
      TICK_RISE <= tick_n & ~tick;
      TICK_FALL <= ~tick_n & tick;
      HALTED    <= (state_n == ST_DONE);
    end
  end

  assign TICK = tick;

`ifdef CPU_CLK_CYCLE_COUNT_EN
  logic [CNT_WIDTH-1:0] cycle_cnt;

  always_ff @(posedge MAIN_CLOCK) begin
    if (!RESET_N) begin
      cycle_cnt <= '0;
    end else if (tick_n && !tick) begin
      cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
    end
  end

  assign CYCLE_COUNT = cycle_cnt;
`else
  assign CYCLE_COUNT = '0;
`endif

endmodule

// File: doc/cpu_clock_controller.md
# cpu_clock_controller

Programmable CPU tick generator. Derives the processor's TICK from MAIN_CLOCK with a run-time divide ratio, free-running and single-step modes, and a glitch-free stop on PROCESS_FINISHED. Replaces the fixed divide-by-2 tick source and sits between the board clock and every CPU-side register bank clocked or enabled by TICK.

## Interface
- DIV_WIDTH, 8: width of DIVIDE; half-period = DIVIDE+1 MAIN_CLOCK cycles.
- CNT_WIDTH, 16: width of CYCLE_COUNT.
- MAIN_CLOCK  in  1  sole clock, all logic on rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- START  in  1  level/pulse; leaves IDLE or DONE.
- STEP_MODE  in  1  0 = free-run, 1 = single-step.
- STEP_REQ  in  1  requests one TICK period in step mode.
- PROCESS_FINISHED  in  1  stop request.
- DIVIDE  in  DIV_WIDTH  half-period minus one.
- TICK  out  1  generated CPU tick, registered.
- TICK_RISE  out  1  one-cycle pulse, first cycle TICK is 1.
- TICK_FALL  out  1  one-cycle pulse, first cycle TICK is 0 after a high phase.
- HALTED  out  1  high in DONE.
- CYCLE_COUNT  out  CNT_WIDTH  TICK rising-edge count (macro-gated).

## Operation
- States: IDLE, RUN, STEP_WAIT, STEP_HI, STEP_LO, DONE.
- Reset: state IDLE; TICK, TICK_RISE, TICK_FALL, HALTED = 0; divider counter = 0; CYCLE_COUNT = 0.
- IDLE: TICK low. START -> RUN if STEP_MODE=0, else STEP_WAIT.
- RUN: TICK toggles after DIVIDE+1 cycles in each phase; DIVIDE latched at the start of each phase (mid-phase changes apply at the next phase). DIVIDE=0 toggles every cycle.
- RUN, STEP_MODE=1: takes effect at the end of the current low phase -> STEP_WAIT. Never truncates a phase.
- STEP_WAIT: TICK low. STEP_MODE=0 -> RUN. STEP_REQ -> STEP_HI.
- STEP_HI: TICK high DIVIDE+1 cycles -> STEP_LO. STEP_LO: TICK low DIVIDE+1 cycles -> STEP_WAIT. STEP_REQ in STEP_HI/STEP_LO is ignored, not queued.
- PROCESS_FINISHED, any active state:
  - TICK high: the high phase completes normally.
  - TICK low: stop immediately.
  - Then DONE. No runt pulses.
- DONE: TICK low, HALTED=1. START with PROCESS_FINISHED low -> restart as from IDLE, HALTED cleared the same edge.
- Priority: RESET_N > PROCESS_FINISHED > STEP_MODE change > START/STEP_REQ.
- Divider counter is DIV_WIDTH bits, compares to the latched DIVIDE, and never wraps past it.
- CYCLE_COUNT increments on every TICK_RISE and wraps modulo 2^CNT_WIDTH.

## Timing
- START sampled at edge k -> TICK=1 and TICK_RISE=1 from edge k (visible cycle k+1).
- Free-run period = 2*(DIVIDE+1) MAIN_CLOCK cycles, 50% duty.
- STEP_REQ sampled at edge k -> TICK high edges k..k+DIVIDE; low again at edge k+DIVIDE+1.
- TICK_RISE/TICK_FALL coincide with TICK's transition edge, one cycle wide.
- HALTED rises on the same edge TICK is (or stays) low on entering DONE.
- All outputs registered; no combinational input-to-output paths.

## Configuration
- CPU_CLK_CYCLE_COUNT_EN defined: CYCLE_COUNT counter built as described.
- Not defined: CYCLE_COUNT tied to 0 and no counter flops; all other behaviour identical.

## Structure
- Shared package: state encoding typedef (6 states), default DIV_WIDTH/CNT_WIDTH constants.
- One sub-module, cpu_clock_phase_timer: loads the latched DIVIDE and asserts phase_done after DIVIDE+1 cycles. The FSM and pulse outputs stay in the top level.

## Test plan
- Reset mid-RUN with DIVIDE=3, TICK high -> next edge TICK=0, state IDLE, CYCLE_COUNT=0, HALTED=0.
- START, DIVIDE=0, STEP_MODE=0 -> TICK toggles every cycle; 10 rises give CYCLE_COUNT=10.
- DIVIDE=2, then 5 mid-high-phase -> current high 3 cycles, following low 6 cycles; TICK_RISE/TICK_FALL one cycle each.
- STEP_MODE=1, DIVIDE=1, STEP_REQ pulsed twice 1 cycle apart -> exactly one pulse of 2 high and 2 low cycles, then TICK low in STEP_WAIT.
- PROCESS_FINISHED one cycle into a 4-cycle high phase -> TICK stays high 3 more cycles, falls, HALTED=1; START restarts with TICK high next cycle.
- CNT_WIDTH=4, 17 rises -> CYCLE_COUNT=1; macro undefined -> CYCLE_COUNT=0 throughout.
